i2c_display_target: RTL and testbench
=====================================

Name: i2c_display_target

Overview:
- Behavioural-synthesizable I2C target that models the SSD1306-style OLED panel on the far end of the DTCU's I2C link.
- Decodes address, control and payload bytes, ACKs the master, and streams data bytes into a 1 KiB frame-buffer write port.
- Exposes command bytes separately on a one-cycle strobe.
- Used in DTCU system benches and as the on-chip display stand-in for loopback configurations.

Parameters:
- DEV_ADDR, 7'h3C, 7-bit target address that is ACKed.
- FB_ADDR_W, 10, frame-buffer address width (1024 bytes).
- SYNC_STAGES, 2, synchronizer flops on SCL and SDA_IN (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 8x the SCL frequency.
- reset  in  1  asynchronous, active-low reset.
- SCL  in  1  bus clock from the master.
- SDA_IN  in  1  resolved SDA line.
- SDA_OUT  out  1  target open-drain drive: 0 pulls low (ACK), 1 releases.
- busy  out  1  high from an address match until STOP or repeated START.
- wr_en  out  1  one-cycle frame-buffer write strobe.
- wr_addr  out  FB_ADDR_W  frame-buffer write pointer.
- wr_data  out  8  data byte.
- cmd_valid  out  1  one-cycle command strobe.
- cmd_byte  out  8  command byte.
- frame_done  out  1  one-cycle pulse when wr_addr wraps from 1023 to 0.
- addr_nack  out  1  one-cycle pulse on address mismatch or R/W=1.

Behaviour:
- Reset values (asynchronous): SDA_OUT=1; busy, wr_en, cmd_valid, frame_done, addr_nack = 0; wr_addr=0; wr_data=0; cmd_byte=0; FSM=IDLE.
- Bus decoding:
  - SCL and SDA_IN pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized copies.
  - START: SDA falls while SCL=1. STOP: SDA rises while SCL=1.
  - Data bits are sampled on the synchronized SCL rising edge, MSB first.
- FSM states: IDLE, ADDR, ADDR_ACK, CTRL, CTRL_ACK, PAYLOAD, PAYLOAD_ACK, IGNORE.
- IDLE -> ADDR on START; bit counter cleared.
- ADDR, after 8 bits:
  - If addr[7:1]==DEV_ADDR and addr[0]==0: busy=1 and go to ADDR_ACK.
  - Otherwise: pulse addr_nack, go to IGNORE, and leave SDA released.
- Every *_ACK state:
  - SDA_OUT=0 from the first synchronized SCL falling edge after bit 8 until the next SCL falling edge (the end of the 9th clock).
  - Then release SDA and move to the next state.
- CTRL byte: bit6 (D/C#) selects data(1) or command(0); bit7 (Co) selects single payload(1) or stream(0). Latch both, then go to CTRL_ACK -> PAYLOAD.
- PAYLOAD, on the 8th bit:
  - Data mode: wr_data=byte and wr_en=1 for one clk, issued on the clk after the 8th rising edge is detected. wr_addr increments on the following clk, wrapping 1023->0; frame_done pulses in the same cycle as the wrap.
  - Command mode: cmd_byte=byte and cmd_valid=1 for one clk with the same timing.
  - Then go to PAYLOAD_ACK.
  - After PAYLOAD_ACK: go to CTRL if Co=1, else stay in PAYLOAD.
- The write pointer persists across transactions. Only reset clears it.
- IGNORE: no drive, no strobes, until START or STOP.
- STOP in any state: go to IDLE, busy=0, release SDA, discard any partial byte (no strobe).
- Repeated START in any state: discard partial byte, go to ADDR, busy=0 until the next address match.
- A START or STOP seen while SDA_OUT=0 (protocol violation) is handled as above. SDA is released on the same clk.
- Reset asserted mid-byte releases SDA immediately and returns all outputs to reset values.
- At most one of wr_en and cmd_valid is asserted in any cycle.

Decomposition:
- Shared package dtcu_pkg holds:
  - state enum i2c_tgt_state_t;
  - constants SSD_ADDR=7'h3C, CTRL_CMD=8'h00, CTRL_DATA=8'h40, CO_BIT=7, DC_BIT=6.
- One sub-module, i2c_bus_sync: synchronizers plus scl_rise, scl_fall, start_det and stop_det pulses.

Test Plan:
- START, 0x78, 0x40, then 0xA5, 0x5A, then STOP:
  - ACK low on all four 9th clocks.
  - wr_en twice: (addr 0, 0xA5) then (addr 1, 0x5A).
  - busy drops after STOP.
- START, 0x78, 0x00, then 0xAE, 0xAF, then STOP: cmd_valid twice with 0xAE then 0xAF; wr_en never asserts; wr_addr stays unchanged.
- START, 0x7A (wrong address), then 3 bytes, then STOP: addr_nack pulses once; SDA_OUT stays 1 throughout; no strobes; busy stays 0.
- Stream 1025 data bytes 0x69: last write lands at addr 0; frame_done pulses exactly once, at the 1023->0 wrap.
- START, 0x78, 0x80, 0xAE, 0x40, 0x11, then STOP: cmd_valid carries 0xAE; then wr_en carries 0x11 at the current pointer.
- STOP after 4 bits of a data byte, then reset pulsed low mid-ACK in a second transaction:
  - the partial byte produces no wr_en;
  - on reset, SDA_OUT returns to 1 asynchronously and wr_addr=0.

Source files
------------

// File: rtl/dtcu_pkg.sv
// Shared DTCU definitions: display-target FSM states and SSD1306 protocol constants.
package dtcu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_CTRL,
        ST_CTRL_ACK,
        ST_PAYLOAD,
        ST_PAYLOAD_ACK,
        ST_IGNORE
    } i2c_tgt_state_t;

    localparam logic [6:0]  SSD_ADDR  = 7'h3C;
    localparam logic [7:0]  CTRL_CMD  = 8'h00;
    localparam logic [7:0]  CTRL_DATA = 8'h40;
    localparam int unsigned CO_BIT    = 7;
    localparam int unsigned DC_BIT    = 6;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into the clk domain and emits registered edge and START/STOP pulses.
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_det_o,
    output logic stop_det_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // sda_o is registered alongside the pulses so a data bit lines up with its scl_rise_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            sda_o       <= 1'b1;
            scl_rise_o  <= 1'b0;
            scl_fall_o  <= 1'b0;
            start_det_o <= 1'b0;
            stop_det_o  <= 1'b0;
        end else begin
            scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q  <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q  <= scl_s;
            sda_prev_q  <= sda_s;
            sda_o       <= sda_s;
            scl_rise_o  <= scl_s & ~scl_prev_q;
            scl_fall_o  <= ~scl_s & scl_prev_q;
            start_det_o <= scl_s & scl_prev_q & sda_prev_q & ~sda_s;
            stop_det_o  <= scl_s & scl_prev_q & ~sda_prev_q & sda_s;
        end
    end

endmodule

// File: rtl/i2c_display_target.sv
// SSD1306-style I2C target: decodes address/control/payload bytes, ACKs, and drives
// frame-buffer write and command strobes.
module i2c_display_target
    import dtcu_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = SSD_ADDR,
    parameter int unsigned FB_ADDR_W   = 10,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 SCL,
    input  logic                 SDA_IN,
    output logic                 SDA_OUT,
    output logic                 busy,
    output logic                 wr_en,
    output logic [FB_ADDR_W-1:0] wr_addr,
    output logic [7:0]           wr_data,
    output logic                 cmd_valid,
    output logic [7:0]           cmd_byte,
    output logic                 frame_done,
    output logic                 addr_nack
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst_n      (reset),
        .scl_i      (SCL),
        .sda_i      (SDA_IN),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_det_o(start_det),
        .stop_det_o (stop_det)
    );

    i2c_tgt_state_t       state_q, ack_next_c;
    logic [2:0]           bit_cnt_q;
    logic [6:0]           shift_q;
    logic [7:0]           byte_d;
    logic                 co_q, dc_q;
    logic                 sda_out_q, busy_q, wr_en_q, cmd_valid_q, frame_done_q, addr_nack_q;
    logic [FB_ADDR_W-1:0] wr_addr_q;
    logic [7:0]           wr_data_q, cmd_byte_q;

    assign byte_d = {shift_q, sda_s};

    always_comb begin
        ack_next_c = ST_IDLE;
        case (state_q)
            ST_ADDR_ACK:    ack_next_c = ST_CTRL;
            ST_CTRL_ACK:    ack_next_c = ST_PAYLOAD;
            ST_PAYLOAD_ACK: ack_next_c = co_q ? ST_CTRL : ST_PAYLOAD;
            default:        ack_next_c = ST_IDLE;
        endcase
    end

    // STOP/START override everything, which also drops any partial byte and any ACK drive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 7'd0;
            co_q         <= 1'b0;
            dc_q         <= 1'b0;
            sda_out_q    <= 1'b1;
            busy_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 8'd0;
            cmd_valid_q  <= 1'b0;
            cmd_byte_q   <= 8'd0;
            frame_done_q <= 1'b0;
            addr_nack_q  <= 1'b0;
        end else begin
            wr_en_q      <= 1'b0;
            cmd_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            addr_nack_q  <= 1'b0;
            if (wr_en_q) begin
                wr_addr_q    <= wr_addr_q + FB_ADDR_W'(1);
                frame_done_q <= &wr_addr_q;
            end
            if (stop_det) begin
                state_q   <= ST_IDLE;
                busy_q    <= 1'b0;
                sda_out_q <= 1'b1;
                bit_cnt_q <= 3'd0;
            end else if (start_det) begin
                state_q   <= ST_ADDR;
                busy_q    <= 1'b0;
                sda_out_q <= 1'b1;
                bit_cnt_q <= 3'd0;
            end else begin
                case (state_q)
                    ST_ADDR, ST_CTRL, ST_PAYLOAD: begin
                        if (scl_rise) begin
                            shift_q   <= byte_d[6:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (state_q == ST_ADDR) begin
                                    if (byte_d[7:1] == DEV_ADDR && !byte_d[0]) begin
                                        busy_q  <= 1'b1;
                                        state_q <= ST_ADDR_ACK;
                                    end else begin
                                        addr_nack_q <= 1'b1;
                                        state_q     <= ST_IGNORE;
                                    end
                                end else if (state_q == ST_CTRL) begin
                                    co_q    <= byte_d[CO_BIT];
                                    dc_q    <= byte_d[DC_BIT];
                                    state_q <= ST_CTRL_ACK;
                                end else begin
                                    if (dc_q) begin
                                        wr_en_q   <= 1'b1;
                                        wr_data_q <= byte_d;
                                    end else begin
                                        cmd_valid_q <= 1'b1;
                                        cmd_byte_q  <= byte_d;
                                    end
                                    state_q <= ST_PAYLOAD_ACK;
                                end
                            end
                        end
                    end
                    // First SCL fall pulls SDA low, the next one (end of 9th clock) releases it.
                    ST_ADDR_ACK, ST_CTRL_ACK, ST_PAYLOAD_ACK: begin
                        if (scl_fall) begin
                            if (sda_out_q) begin
                                sda_out_q <= 1'b0;
                            end else begin
                                sda_out_q <= 1'b1;
                                state_q   <= ack_next_c;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign SDA_OUT    = sda_out_q;
    assign busy       = busy_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_byte   = cmd_byte_q;
    assign frame_done = frame_done_q;
    assign addr_nack  = addr_nack_q;

endmodule

// File: tb/tb_i2c_display_target.sv
// Bench for i2c_display_target: bit-banged I2C master, transaction table and strobe scoreboard.
module tb_i2c_display_target;
    import dtcu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m;
    logic       sda_m;
    logic       sda_line;
    logic       SDA_OUT, busy, wr_en, cmd_valid, frame_done, addr_nack;
    logic [9:0] wr_addr;
    logic [7:0] wr_data, cmd_byte;

    always #5 clk = ~clk;

    assign sda_line = sda_m & SDA_OUT;

    i2c_display_target dut (
        .clk       (clk),
        .reset     (reset),
        .SCL       (scl_m),
        .SDA_IN    (sda_line),
        .SDA_OUT   (SDA_OUT),
        .busy      (busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cmd_valid (cmd_valid),
        .cmd_byte  (cmd_byte),
        .frame_done(frame_done),
        .addr_nack (addr_nack)
    );

    typedef struct packed {
        logic       is_cmd;
        logic [9:0] addr;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        int         n;
        logic [7:0] b [6];
        int         exp_wr;
        int         exp_cmd;
        int         exp_nack;
    } vec_t;

    ev_t        exp_q [$];
    ev_t        mon_e;
    vec_t       vecs [6];
    int         checks = 0;
    int         failures = 0;
    int         n_wr = 0, n_cmd = 0, n_nack = 0, n_frame = 0;
    int         exp_frames = 0;
    logic       busy_seen, low_seen;
    logic [9:0] exp_ptr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        wait_clks(2); sda_m = b;
        wait_clks(3); scl_m = 1'b1;
        wait_clks(3); scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string nm);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        wait_clks(2); sda_m = 1'b1;
        wait_clks(3); scl_m = 1'b1;
        wait_clks(1); chk(nm, 32'(SDA_OUT), 32'(!exp_ack));
        wait_clks(2); scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl_m = 1'b1;
        wait_clks(3); sda_m = 1'b0;
        wait_clks(3); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clks(2); sda_m = 1'b0;
        wait_clks(3); scl_m = 1'b1;
        wait_clks(3); sda_m = 1'b1;
        wait_clks(6);
    endtask

    task automatic push_payload(input logic dc, input logic [7:0] d);
        exp_q.push_back('{is_cmd: !dc, addr: exp_ptr, data: d});
        if (dc) begin
            if (exp_ptr == 10'd1023) exp_frames++;
            exp_ptr = exp_ptr + 10'd1;
        end
    endtask

    // Scoreboard side: every strobe pops and checks the oldest expected event.
    always @(negedge clk) begin
        if (reset) begin
            if (busy) busy_seen = 1'b1;
            if (!SDA_OUT) low_seen = 1'b1;
            if (addr_nack) n_nack++;
            if (frame_done) begin
                n_frame++;
                chk("frame_done_at_wrap", 32'(wr_addr), 32'd0);
            end
            if (wr_en || cmd_valid) begin
                chk("strobe_exclusive", 32'(wr_en & cmd_valid), 32'd0);
                if (wr_en) n_wr++;
                if (cmd_valid) n_cmd++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'({wr_en, cmd_valid}), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("strobe_kind", 32'(cmd_valid), 32'(mon_e.is_cmd));
                    if (mon_e.is_cmd) begin
                        chk("cmd_byte", 32'(cmd_byte), 32'(mon_e.data));
                    end else begin
                        chk("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
                        chk("wr_data", 32'(wr_data), 32'(mon_e.data));
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] addr_b;
        int         wr0, cmd0, nk0, f0;
        logic       acked, ph, co, dc;

        vecs[0].n = 4; vecs[0].b = '{8'h78, CTRL_DATA, 8'hA5, 8'h5A, 8'h00, 8'h00};
        vecs[0].exp_wr = 2; vecs[0].exp_cmd = 0; vecs[0].exp_nack = 0;
        vecs[1].n = 4; vecs[1].b = '{8'h78, CTRL_CMD, 8'hAE, 8'hAF, 8'h00, 8'h00};
        vecs[1].exp_wr = 0; vecs[1].exp_cmd = 2; vecs[1].exp_nack = 0;
        vecs[2].n = 4; vecs[2].b = '{8'h7A, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00};
        vecs[2].exp_wr = 0; vecs[2].exp_cmd = 0; vecs[2].exp_nack = 1;
        vecs[3].n = 3; vecs[3].b = '{8'h79, CTRL_DATA, 8'h01, 8'h00, 8'h00, 8'h00};
        vecs[3].exp_wr = 0; vecs[3].exp_cmd = 0; vecs[3].exp_nack = 1;
        vecs[4].n = 5; vecs[4].b = '{8'h78, 8'h80, 8'hAE, CTRL_DATA, 8'h11, 8'h00};
        vecs[4].exp_wr = 1; vecs[4].exp_cmd = 1; vecs[4].exp_nack = 0;
        vecs[5].n = 5; vecs[5].b = '{8'h78, 8'hC0, 8'h3C, CTRL_CMD, 8'hE3, 8'h00};
        vecs[5].exp_wr = 1; vecs[5].exp_cmd = 1; vecs[5].exp_nack = 0;

        reset = 1'b0; scl_m = 1'b1; sda_m = 1'b1; exp_ptr = 10'd0;
        busy_seen = 1'b0; low_seen = 1'b0;
        wait_clks(3);
        chk("rst_sda_out",    32'(SDA_OUT),    32'd1);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_wr_en",      32'(wr_en),      32'd0);
        chk("rst_cmd_valid",  32'(cmd_valid),  32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_addr_nack",  32'(addr_nack),  32'd0);
        chk("rst_wr_addr",    32'(wr_addr),    32'd0);
        chk("rst_wr_data",    32'(wr_data),    32'd0);
        chk("rst_cmd_byte",   32'(cmd_byte),   32'd0);
        reset = 1'b1;
        wait_clks(4);

        for (int v = 0; v < 6; v++) begin
            busy_seen = 1'b0; low_seen = 1'b0;
            wr0 = n_wr; cmd0 = n_cmd; nk0 = n_nack;
            acked = (vecs[v].b[0][7:1] == SSD_ADDR) && !vecs[v].b[0][0];
            ph = 1'b0; co = 1'b0; dc = 1'b0;
            i2c_start();
            send_byte(vecs[v].b[0], acked, "addr_ack");
            for (int i = 1; i < vecs[v].n; i++) begin
                if (acked) begin
                    if (!ph) begin
                        co = vecs[v].b[i][CO_BIT];
                        dc = vecs[v].b[i][DC_BIT];
                        ph = 1'b1;
                    end else begin
                        push_payload(dc, vecs[v].b[i]);
                        ph = !co;
                    end
                end
                send_byte(vecs[v].b[i], acked, "byte_ack");
            end
            i2c_stop();
            wait_clks(4);
            chk("vec_busy_after_stop", 32'(busy),       32'd0);
            chk("vec_busy_seen",       32'(busy_seen),  32'(vecs[v].exp_nack == 0));
            chk("vec_ack_driven",      32'(low_seen),   32'(vecs[v].exp_nack == 0));
            chk("vec_wr_count",        32'(n_wr - wr0),  32'(vecs[v].exp_wr));
            chk("vec_cmd_count",       32'(n_cmd - cmd0), 32'(vecs[v].exp_cmd));
            chk("vec_nack_count",      32'(n_nack - nk0), 32'(vecs[v].exp_nack));
            chk("vec_wr_ptr",          32'(wr_addr),    32'(exp_ptr));
            chk("vec_pending",         32'(exp_q.size()), 32'd0);
        end

        // STOP in the middle of a data byte must not strobe.
        wr0 = n_wr;
        i2c_start();
        send_byte(8'h78, 1'b1, "partial_addr_ack");
        send_byte(CTRL_DATA, 1'b1, "partial_ctrl_ack");
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        i2c_stop();
        wait_clks(4);
        chk("partial_no_write", 32'(n_wr - wr0), 32'd0);
        chk("partial_ptr",      32'(wr_addr),    32'(exp_ptr));
        chk("partial_busy",     32'(busy),       32'd0);

        // Reset asserted while the target is holding the address ACK low.
        addr_b = 8'h78;
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(addr_b[i]);
        wait_clks(2); sda_m = 1'b1;
        wait_clks(3); scl_m = 1'b1;
        wait_clks(1);
        chk("ack_before_reset",  32'(SDA_OUT), 32'd0);
        chk("busy_before_reset", 32'(busy),    32'd1);
        chk("ptr_before_reset",  32'(wr_addr), 32'(exp_ptr));
        #2 reset = 1'b0;
        #1;
        chk("async_rst_sda_out", 32'(SDA_OUT), 32'd1);
        chk("async_rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("async_rst_busy",    32'(busy),    32'd0);
        exp_ptr = 10'd0;
        exp_q.delete();
        scl_m = 1'b1; sda_m = 1'b1;
        wait_clks(3);
        reset = 1'b1;
        wait_clks(4);

        // 1025-byte stream from pointer 0: one wrap, last byte lands at 0.
        f0 = n_frame;
        i2c_start();
        send_byte(8'h78, 1'b1, "stream_addr_ack");
        send_byte(CTRL_DATA, 1'b1, "stream_ctrl_ack");
        for (int i = 0; i < 1025; i++) begin
            push_payload(1'b1, 8'h69);
            send_byte(8'h69, 1'b1, "stream_ack");
        end
        i2c_stop();
        wait_clks(4);
        chk("stream_frame_count", 32'(n_frame - f0), 32'd1);
        chk("stream_frame_model", 32'(n_frame),      32'(exp_frames));
        chk("stream_final_ptr",   32'(wr_addr),      32'(exp_ptr));
        chk("stream_pending",     32'(exp_q.size()), 32'd0);
        chk("stream_busy",        32'(busy),         32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
